// File: rtl/product_accumulator_if.sv
// Product stream (in_*) and burst result (out_*) handshakes.
// The slave side belongs to product_accumulator.
interface product_accumulator_if #(
  parameter int PW = 8,
  parameter int AW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_product;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_overflow;

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums bursts of COUNT unsigned products into an AW-bit result with a sticky overflow flag.
// Optional macro PRODACC_SATURATE_EN clamps the accumulator on overflow; otherwise it wraps.
module product_accumulator #(
  parameter int PW    = 8,
  parameter int AW    = 16,
  parameter int COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  product_accumulator_if.slave  bus
);
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [AW-1:0] ACC_MAX = {AW{1'b1}};

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t        state_r;
  logic [AW-1:0] acc_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [AW-1:0] out_sum_r;
  logic          out_overflow_r;

  logic [AW:0]   sum_wide_s;
  logic [AW-1:0] acc_next_s;
  logic          ovf_next_s;
  logic          last_s;
  logic          in_fire_s;
  logic          out_fire_s;

  // Zero-extends the product and keeps the carry-out in the top bit.
  function automatic logic [AW:0] add_ext(input logic [AW-1:0] a, input logic [PW-1:0] p);
    add_ext = {1'b0, a} + {{(AW + 1 - PW){1'b0}}, p};
  endfunction

  // Next accumulator value, overflow flag and burst-completion decode.
  always_comb begin
    in_fire_s  = in_ready_r & bus.in_valid;
    out_fire_s = out_valid_r & bus.out_ready;
    sum_wide_s = add_ext(acc_r, bus.in_product);
    ovf_next_s = ovf_r | sum_wide_s[AW];
`ifdef PRODACC_SATURATE_EN
    // Once clamped, the accumulator stays at the ceiling for the rest of the burst.
    if (ovf_next_s) begin
      acc_next_s = ACC_MAX;
    end else begin
      acc_next_s = sum_wide_s[AW-1:0];
    end
`else
    acc_next_s = sum_wide_s[AW-1:0];
`endif
    last_s = (count_r == CW'(COUNT - 1));
  end

  // Burst FSM: ACCUM collects products, HOLD presents the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ACCUM;
      acc_r          <= {AW{1'b0}};
      count_r        <= {CW{1'b0}};
      ovf_r          <= 1'b0;
      in_ready_r     <= 1'b1;
      out_valid_r    <= 1'b0;
      out_sum_r      <= {AW{1'b0}};
      out_overflow_r <= 1'b0;
    end else if (clear) begin
      // Abort drops any handshake this cycle; the last result stays visible.
      state_r     <= ACCUM;
      acc_r       <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_fire_s) begin
            if (last_s) begin
              out_sum_r      <= acc_next_s;
              out_overflow_r <= ovf_next_s;
              out_valid_r    <= 1'b1;
              in_ready_r     <= 1'b0;
              state_r        <= HOLD;
              acc_r          <= {AW{1'b0}};
              count_r        <= {CW{1'b0}};
              ovf_r          <= 1'b0;
            end else begin
              acc_r   <= acc_next_s;
              count_r <= count_r + CW'(1);
              ovf_r   <= ovf_next_s;
            end
          end
        end
        HOLD: begin
          if (out_fire_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ACCUM;
          end
        end
        default: begin
          state_r     <= ACCUM;
          acc_r       <= {AW{1'b0}};
          count_r     <= {CW{1'b0}};
          ovf_r       <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_sum      = out_sum_r;
  assign bus.out_overflow = out_overflow_r;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed plus randomized bench for product_accumulator: default build, AW=9 and COUNT=1 instances.
module tb_product_accumulator;
  logic clk;
  logic rst_n;
  logic clear;
  int   checks   = 0;
  int   failures = 0;

  product_accumulator_if #(.PW(8), .AW(16)) a ();
  product_accumulator_if #(.PW(8), .AW(9))  b ();
  product_accumulator_if #(.PW(8), .AW(16)) c ();

  product_accumulator #(.PW(8), .AW(16), .COUNT(4)) d0 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(a.slave));
  product_accumulator #(.PW(8), .AW(9),  .COUNT(4)) d1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(b.slave));
  product_accumulator #(.PW(8), .AW(16), .COUNT(1)) d2 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(c.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one product on instance a, starting and ending on a falling edge.
  task automatic put0(input logic [7:0] v);
    int n;
    n = 0;
    a.in_valid   = 1'b1;
    a.in_product = v;
    while (!a.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("put0_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    a.in_valid = 1'b0;
  endtask

  task automatic ack0();
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
  endtask

  int       vals [3] = '{5, 6, 7};
  int       tot;
  int       exp_sum;
  int       p;
  bit       exp_ovf;
  bit       ev;
  int       es;
  int       cur[$];

  initial begin
    clk = 1'b0; rst_n = 1'b0; clear = 1'b0;
    a.in_valid = 1'b0; a.in_product = 8'd0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_product = 8'd0; b.out_ready = 1'b0;
    c.in_valid = 1'b0; c.in_product = 8'd0; c.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", a.out_valid, 0);
    chk("reset_out_sum", a.out_sum, 0);
    chk("reset_out_overflow", a.out_overflow, 0);
    chk("reset_in_ready", a.in_ready, 1);

    // Basic burst of four 225s with one-cycle result latency.
    for (int i = 0; i < 4; i++) put0(8'd225);
    chk("basic_valid", a.out_valid, 1);
    chk("basic_sum", a.out_sum, 900);
    chk("basic_ovf", a.out_overflow, 0);
    chk("basic_hold_ready", a.in_ready, 0);
    ack0();
    chk("basic_valid_drop", a.out_valid, 0);
    chk("basic_ready_back", a.in_ready, 1);

    // Backpressure: products of 7 offered during HOLD must be ignored.
    for (int i = 0; i < 4; i++) put0(8'd1);
    a.in_valid = 1'b1; a.in_product = 8'd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum", a.out_sum, 4);
      chk("bp_ready", a.in_ready, 0);
      chk("bp_valid", a.out_valid, 1);
      @(negedge clk);
    end
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0; a.in_valid = 1'b0;
    chk("bp_release", a.out_valid, 0);
    for (int i = 0; i < 4; i++) put0(8'd2);
    chk("bp_next_sum", a.out_sum, 8);
    ack0();

    // Clear mid-burst, together with a third offered product.
    put0(8'd9); put0(8'd9);
    a.in_valid = 1'b1; a.in_product = 8'd9; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; a.in_valid = 1'b0;
    chk("clr_sum_kept", a.out_sum, 8);
    chk("clr_valid", a.out_valid, 0);
    chk("clr_ready", a.in_ready, 1);
    for (int i = 0; i < 4; i++) put0(8'd1);
    chk("clr_sum", a.out_sum, 4);
    chk("clr_ovf", a.out_overflow, 0);
    ack0();

    // AW=9 instance: first burst 4x225, then random bursts against a plain-sum model.
    for (int k = 0; k < 8; k++) begin
      tot = 0;
      for (int j = 0; j < 4; j++) begin
        p = (k == 0) ? 225 : int'($urandom_range(0, 255));
        chk("d1_ready", b.in_ready, 1);
        b.in_valid = 1'b1; b.in_product = 8'(p);
        tot += p;
        @(negedge clk);
      end
      b.in_valid = 1'b0;
      exp_ovf = (tot > 511);
`ifdef PRODACC_SATURATE_EN
      exp_sum = exp_ovf ? 511 : tot;
`else
      exp_sum = tot % 512;
`endif
      chk("d1_valid", b.out_valid, 1);
      chk("d1_sum", b.out_sum, 32'(exp_sum));
      chk("d1_ovf", b.out_overflow, 32'(exp_ovf));
      b.out_ready = 1'b1;
      @(negedge clk);
      b.out_ready = 1'b0;
    end

    // COUNT=1 instance with out_ready tied high: a handshake every second cycle.
    c.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c.in_product = 8'(vals[i / 2]);
      chk("d2_ready", c.in_ready, 32'(i % 2 == 0));
      chk("d2_valid", c.out_valid, 32'(i % 2 == 1));
      if (i % 2 == 1) chk("d2_sum", c.out_sum, 32'(vals[i / 2]));
      @(negedge clk);
    end
    c.in_valid = 1'b0;

    // Random traffic on the default instance against a queue-of-products model.
    ev = 1'b0; es = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk("rnd_valid", a.out_valid, 32'(ev));
      chk("rnd_ready", a.in_ready, 32'(!ev));
      if (ev) chk("rnd_sum", a.out_sum, 32'(es));
      if (ev) chk("rnd_ovf", a.out_overflow, 0);
      a.in_valid   = 1'($urandom_range(0, 1));
      a.in_product = 8'($urandom_range(0, 255));
      a.out_ready  = ($urandom_range(0, 3) != 0);
      if (ev) begin
        if (a.out_ready) ev = 1'b0;
      end else if (a.in_valid) begin
        cur.push_back(int'(a.in_product));
        if (cur.size() == 4) begin
          es = cur.sum();
          ev = 1'b1;
          cur.delete();
        end
      end
      @(negedge clk);
    end
    a.in_valid = 1'b0; a.out_ready = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // Asynchronous reset mid-burst discards the partial sum.
    put0(8'd2); put0(8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", a.out_valid, 0);
    chk("rst_async_sum", a.out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_sum", a.out_sum, 0);
    chk("rst_in_ready", a.in_ready, 1);
    for (int i = 0; i < 4; i++) put0(8'd3);
    chk("rst_next_valid", a.out_valid, 1);
    chk("rst_next_sum", a.out_sum, 12);
    ack0();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
